// File: rtl/mem_req_responder_if.sv
// Request/return bus between an initiator and mem_req_responder.
// The initiator drives wr_*/rd_* requests with no backpressure; the responder
// drives the *_ret_* acknowledgements and the running ack counters.
interface mem_req_responder_if;
    logic [15:0] wr_address;
    logic        wr_en;
    logic [15:0] wr_data;
    logic [15:0] wr_ret_address;
    logic        wr_ret_ack;

    logic [15:0] rd_address;
    logic        rd_en;
    logic [15:0] rd_ret_data;
    logic [15:0] rd_ret_address;
    logic        rd_ret_ack;

    logic [15:0] wr_count;
    logic [15:0] rd_count;

    modport master (
        output wr_address, wr_en, wr_data, rd_address, rd_en,
        input  wr_ret_address, wr_ret_ack,
        input  rd_ret_data, rd_ret_address, rd_ret_ack,
        input  wr_count, rd_count
    );

    modport slave (
        input  wr_address, wr_en, wr_data, rd_address, rd_en,
        output wr_ret_address, wr_ret_ack,
        output rd_ret_data, rd_ret_address, rd_ret_ack,
        output wr_count, rd_count
    );
endinterface

// File: rtl/mem_req_responder.sv
// Behavioural memory target: 2^AW x 16 word array with independent
// fixed-latency write and read return pipelines and per-channel ack counters.

// One return channel: a request captured at edge k reaches the last stage at
// edge k+LATENCY, so the ack is high for the cycle that follows that edge.
// Payload stages only load behind a valid beat, which makes the output payload
// hold its last acknowledged value while the ack is low.
module mem_req_responder_pipe #(
    parameter int LATENCY = 3,
    parameter int PW      = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_vld,
    input  logic [PW-1:0] in_pld,
    output logic          out_vld,
    output logic [PW-1:0] out_pld,
    output logic [15:0]   count
);
    logic [LATENCY:0]         vld_pipe;
    logic [LATENCY:0][PW-1:0] pld_pipe;

    // Shift valid/payload down the pipe; count on the edge that raises the ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            pld_pipe <= '0;
            count    <= '0;
        end else begin
            vld_pipe <= {vld_pipe[LATENCY-1:0], in_vld};
            if (in_vld) pld_pipe[0] <= in_pld;
            for (int i = 1; i <= LATENCY; i++) begin
                if (vld_pipe[i-1]) pld_pipe[i] <= pld_pipe[i-1];
            end
            if (vld_pipe[LATENCY-1]) count <= count + 16'd1;
        end
    end

    assign out_vld = vld_pipe[LATENCY];
    assign out_pld = pld_pipe[LATENCY];
endmodule

module mem_req_responder #(
    parameter int AW      = 8,
    parameter int LATENCY = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_req_responder_if.slave   bus
);
    typedef struct packed {
        logic [15:0] address;
    } wr_ret_t;

    typedef struct packed {
        logic [15:0] address;
        logic [15:0] data;
    } rd_ret_t;

    localparam int DEPTH = 2 ** AW;

    // Array contents start at zero and are never touched by reset.
    logic [15:0] mem [DEPTH] = '{default: 16'h0000};

    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    wr_ret_t       wr_req;
    rd_ret_t       rd_req;
    wr_ret_t       wr_ret;
    rd_ret_t       rd_ret;

    // Upper address bits alias in the array but travel intact to the return.
    assign wr_idx         = bus.wr_address[AW-1:0];
    assign rd_idx         = bus.rd_address[AW-1:0];
    assign wr_req.address = bus.wr_address;
    assign rd_req.address = bus.rd_address;
    // Combinational read captured by the pipe on the same edge as any write,
    // so a same-edge write to the same index is not yet visible.
    assign rd_req.data    = mem[rd_idx];

    // Commit writes; requests seen while reset is asserted are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n && bus.wr_en) mem[wr_idx] <= bus.wr_data;
    end

    mem_req_responder_pipe #(.LATENCY(LATENCY), .PW($bits(wr_ret_t))) u_wr_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (bus.wr_en),
        .in_pld  (wr_req),
        .out_vld (bus.wr_ret_ack),
        .out_pld (wr_ret),
        .count   (bus.wr_count)
    );

    mem_req_responder_pipe #(.LATENCY(LATENCY), .PW($bits(rd_ret_t))) u_rd_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (bus.rd_en),
        .in_pld  (rd_req),
        .out_vld (bus.rd_ret_ack),
        .out_pld (rd_ret),
        .count   (bus.rd_count)
    );

    assign bus.wr_ret_address = wr_ret.address;
    assign bus.rd_ret_address = rd_ret.address;
    assign bus.rd_ret_data    = rd_ret.data;
endmodule

// File: tb/tb_mem_req_responder.sv
// Bench for mem_req_responder: directed scenarios plus random traffic, all
// checked every cycle against an event-scheduled memory model.
module tb_mem_req_responder;
    localparam int AW  = 8;
    localparam int LAT = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    mem_req_responder_if bus();

    mem_req_responder #(.AW(AW), .LATENCY(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    // Model: word array plus return slots indexed by the edge number on
    // which each acknowledgement is due.
    logic [15:0] mmem [2**AW];
    bit          s_wv [16];
    logic [15:0] s_wa [16];
    bit          s_rv [16];
    logic [15:0] s_ra [16];
    logic [15:0] s_rd [16];
    logic [15:0] m_wcnt = 16'h0;
    logic [15:0] m_rcnt = 16'h0;
    int          e = 0;

    initial begin
        for (int i = 0; i < 2**AW; i++) mmem[i] = 16'h0;
        for (int i = 0; i < 16; i++) begin
            s_wv[i] = 1'b0; s_rv[i] = 1'b0;
        end
    end

    // Record each sampled request against the edge its return is due.
    always @(posedge clk) begin
        int d;
        e++;
        d = (e + LAT) % 16;
        if (rst_n) begin
            if (bus.rd_en) begin
                s_rv[d] = 1'b1;
                s_ra[d] = bus.rd_address;
                s_rd[d] = mmem[bus.rd_address[AW-1:0]];
            end
            if (bus.wr_en) begin
                mmem[bus.wr_address[AW-1:0]] = bus.wr_data;
                s_wv[d] = 1'b1;
                s_wa[d] = bus.wr_address;
            end
        end
    end

    // Reset discards everything in flight and zeroes the counters.
    always @(negedge rst_n) begin
        for (int i = 0; i < 16; i++) begin
            s_wv[i] = 1'b0; s_rv[i] = 1'b0;
        end
        m_wcnt = 16'h0;
        m_rcnt = 16'h0;
    end

    // Compare DUT outputs to the model every cycle.
    always @(negedge clk) begin
        int s;
        if (!rst_n) begin
            chk("rst_wr_ret_ack", bus.wr_ret_ack, 0);
            chk("rst_rd_ret_ack", bus.rd_ret_ack, 0);
            chk("rst_wr_ret_address", bus.wr_ret_address, 0);
            chk("rst_rd_ret_address", bus.rd_ret_address, 0);
            chk("rst_rd_ret_data", bus.rd_ret_data, 0);
            chk("rst_wr_count", bus.wr_count, 0);
            chk("rst_rd_count", bus.rd_count, 0);
        end else begin
            s = e % 16;
            chk("wr_ret_ack", bus.wr_ret_ack, s_wv[s]);
            if (s_wv[s]) begin
                chk("wr_ret_address", bus.wr_ret_address, s_wa[s]);
                m_wcnt = m_wcnt + 16'd1;
                s_wv[s] = 1'b0;
            end
            chk("rd_ret_ack", bus.rd_ret_ack, s_rv[s]);
            if (s_rv[s]) begin
                chk("rd_ret_address", bus.rd_ret_address, s_ra[s]);
                chk("rd_ret_data", bus.rd_ret_data, s_rd[s]);
                m_rcnt = m_rcnt + 16'd1;
                s_rv[s] = 1'b0;
            end
            chk("wr_count", bus.wr_count, m_wcnt);
            chk("rd_count", bus.rd_count, m_rcnt);
        end
    end

    // Present one request set for exactly one sampling edge.
    task automatic cyc(input bit we, input logic [15:0] wa, input logic [15:0] wd,
                       input bit re, input logic [15:0] ra);
        bus.wr_en = we; bus.wr_address = wa; bus.wr_data = wd;
        bus.rd_en = re; bus.rd_address = ra;
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Wait (bounded) for the next read return and check it literally.
    task automatic wait_rd(input string nm, input logic [15:0] ed,
                           input logic [15:0] ea, output int n);
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.rd_ret_ack) break;
        end
        chk({nm, "_timeout"}, int'(n < 20), 1);
        if (n < 20) begin
            chk({nm, "_data"}, bus.rd_ret_data, ed);
            chk({nm, "_address"}, bus.rd_ret_address, ea);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.wr_en = 1'b0; bus.wr_address = 16'h0; bus.wr_data = 16'h0;
        bus.rd_en = 1'b0; bus.rd_address = 16'h0;
        #1 rst_n = 1'b0;

        // Requests held during reset are ignored.
        bus.wr_en = 1'b1; bus.wr_address = 16'h0096; bus.wr_data = 16'hDEAD;
        bus.rd_en = 1'b1; bus.rd_address = 16'h0096;
        repeat (4) begin
            @(negedge clk);
            chk("rst_hold_rd_ack", bus.rd_ret_ack, 0);
            chk("rst_hold_wr_count", bus.wr_count, 0);
        end
        bus.wr_en = 1'b0; bus.rd_en = 1'b0;
        #1 rst_n = 1'b1;
        cyc(1'b0, 16'h0, 16'h0, 1'b1, 16'h0096);
        wait_rd("rst_read", 16'h0000, 16'h0096, n);

        // Single write then read with exact latency.
        @(negedge clk);
        cyc(1'b1, 16'h0096, 16'h1234, 1'b0, 16'h0);
        idle(2);
        @(negedge clk);
        chk("wr_lat_early", bus.wr_ret_ack, 0);
        idle(1);
        @(negedge clk);
        chk("wr_lat_ack", bus.wr_ret_ack, 1);
        chk("wr_lat_address", bus.wr_ret_address, 16'h0096);
        idle(1);
        @(negedge clk);
        chk("wr_lat_late", bus.wr_ret_ack, 0);
        cyc(1'b0, 16'h0, 16'h0, 1'b1, 16'h0096);
        idle(3);
        @(negedge clk);
        chk("rd_lat_ack", bus.rd_ret_ack, 1);
        chk("rd_lat_data", bus.rd_ret_data, 16'h1234);
        chk("rd_lat_address", bus.rd_ret_address, 16'h0096);

        // Streaming writes then contiguous reads.
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1'b1, 16'(150 + i), 16'(i), 1'b0, 16'h0);
        fork
            begin
                for (int i = 0; i < 5; i++) cyc(1'b0, 16'h0, 16'h0, 1'b1, 16'(150 + i));
            end
            begin
                for (int j = 0; j < 5; j++) begin
                    int g;
                    wait_rd("stream", 16'(j), 16'(150 + j), g);
                    if (j > 0) chk("stream_gap", g, 0);
                end
            end
        join
        idle(2);
        @(negedge clk);
        chk("stream_wr_count", bus.wr_count, 5);
        chk("stream_rd_count", bus.rd_count, 5);

        // Aliasing through the upper address bits.
        cyc(1'b1, 16'h0196, 16'hBEEF, 1'b0, 16'h0);
        cyc(1'b0, 16'h0, 16'h0, 1'b1, 16'h0096);
        wait_rd("alias", 16'hBEEF, 16'h0096, n);

        // Same-edge read sees old data; next edge sees new data.
        @(negedge clk);
        cyc(1'b1, 16'h0010, 16'h5A5A, 1'b1, 16'h0010);
        cyc(1'b0, 16'h0, 16'h0, 1'b1, 16'h0010);
        wait_rd("hazard_same", 16'h0000, 16'h0010, n);
        wait_rd("hazard_next", 16'h5A5A, 16'h0010, n);
        chk("hazard_gap", n, 0);

        // Reset while four reads are in flight.
        @(negedge clk);
        for (int i = 0; i < 4; i++) cyc(1'b0, 16'h0, 16'h0, 1'b1, 16'(16'h0020 + i));
        @(negedge clk);
        chk("mf_ack0", bus.rd_ret_ack, 1);
        chk("mf_ack0_address", bus.rd_ret_address, 16'h0020);
        idle(1);
        @(negedge clk);
        chk("mf_ack1", bus.rd_ret_ack, 1);
        chk("mf_ack1_address", bus.rd_ret_address, 16'h0021);
        #2 rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("mf_rst_ack", bus.rd_ret_ack, 0);
            chk("mf_rst_count", bus.rd_count, 0);
        end
        #1 rst_n = 1'b1;
        idle(6);
        @(negedge clk);
        chk("mf_after_count", bus.rd_count, 0);
        chk("mf_after_ack", bus.rd_ret_ack, 0);

        // Random traffic biased toward a few indices for hazards.
        for (int i = 0; i < 400; i++) begin
            logic [15:0] wa, ra;
            wa = 16'($urandom);
            ra = 16'($urandom);
            if ($urandom_range(0, 1) == 1) wa[7:0] = 8'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) ra[7:0] = 8'($urandom_range(0, 7));
            cyc(1'($urandom), wa, 16'($urandom), 1'($urandom), ra);
            if (i == 200) begin
                @(negedge clk);
                #2 rst_n = 1'b0;
                @(negedge clk);
                #1 rst_n = 1'b1;
            end
        end
        idle(LAT + 2);

        // Write counter wrap.
        do_reset();
        repeat (65537) cyc(1'b1, 16'($urandom), 16'($urandom), 1'b0, 16'h0);
        idle(LAT + 2);
        @(negedge clk);
        chk("wrap_wr_count", bus.wr_count, 16'h0001);
        chk("wrap_rd_count", bus.rd_count, 16'h0000);
        chk("wrap_model_count", m_wcnt, 16'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
